// File: rtl/jace_video_fetch.sv
// Jupiter Ace video fetch and raster: screen/char RAM fetch pipeline, pixel serialiser,
// sync, blank and frame interrupt generation, all advancing on pix_ce ticks.
module jace_video_fetch #(
  parameter int unsigned H_TOTAL  = 416,
  parameter int unsigned V_TOTAL  = 312,
  parameter int unsigned HS_START = 320,
  parameter int unsigned HS_LEN   = 32,
  parameter int unsigned VS_START = 248,
  parameter int unsigned VS_LEN   = 8,
  parameter int unsigned INT_LEN  = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  output logic [9:0] scr_addr,
  input  logic [7:0] scr_data,
  output logic [9:0] chr_addr,
  input  logic [7:0] chr_data,
  output logic       video,
  output logic       blank,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       int_n
);

  localparam int unsigned CNT_W = 9;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(HS_START);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(HS_START + HS_LEN - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(VS_START);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(VS_START + VS_LEN - 1);
  localparam logic [CNT_W-1:0] INT_END    = CNT_W'(INT_LEN);
  localparam logic [CNT_W-1:0] ACT_LINES  = CNT_W'(192);
  localparam logic [CNT_W-1:0] ACT_TICKS  = CNT_W'(256);
  localparam logic [CNT_W-1:0] DISP_FIRST = CNT_W'(7);
  localparam logic [CNT_W-1:0] DISP_LAST  = CNT_W'(262);

  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             code_inv_r;
  logic [7:0]       pat_r;
  logic             inv_r;
  logic [7:0]       shift;

  logic             fetch;
  logic             disp;
  logic             load_slot;
  logic [7:0]       load_pat;
  logic             pix;

  // Window decode and next pixel selection for the current tick position.
  always_comb begin
    fetch     = (vcount < ACT_LINES) && (hcount < ACT_TICKS);
    disp      = (vcount < ACT_LINES) && (hcount >= DISP_FIRST) && (hcount <= DISP_LAST);
    load_slot = fetch && (hcount[2:0] == 3'd7);
    load_pat  = pat_r ^ {8{inv_r}};
    pix       = load_slot ? load_pat[7] : shift[7];
  end

  // Only the inverse bit of the character code is needed once chr_addr is formed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount     <= '0;
      vcount     <= '0;
      scr_addr   <= '0;
      chr_addr   <= '0;
      code_inv_r <= 1'b0;
      pat_r      <= '0;
      inv_r      <= 1'b0;
      shift      <= '0;
      video      <= 1'b0;
      blank      <= 1'b1;
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
      int_n      <= 1'b1;
    end else if (pix_ce) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? '0 : vcount + CNT_W'(1);
      end else begin
        hcount <= hcount + CNT_W'(1);
      end

      if (fetch) begin
        case (hcount[2:0])
          3'd1: scr_addr <= {vcount[7:3], hcount[7:3]};
          3'd3: begin
            code_inv_r <= scr_data[7];
            chr_addr   <= {scr_data[6:0], vcount[2:0]};
          end
          3'd5: begin
            pat_r <= chr_data;
            inv_r <= code_inv_r;
          end
          default: ;
        endcase
      end

      shift   <= load_slot ? {load_pat[6:0], 1'b0} : {shift[6:0], 1'b0};
      video   <= disp & pix;
      blank   <= ~disp;
      hsync_n <= ~((hcount >= HS_FIRST) && (hcount <= HS_LAST));
      vsync_n <= ~((vcount >= VS_FIRST) && (vcount <= VS_LAST));
      int_n   <= ~((vcount == VS_FIRST) && (hcount < INT_END));
    end
  end

endmodule
